// File: rtl/jtkiwi_romarb_pkg.sv
// Shared types and limits for the ROM arbiter: FSM encoding and channel-count bounds.
package jtkiwi_romarb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam int CH_MIN = 2;
    localparam int CH_MAX = 8;

    // Index of the k-th candidate after 'base', wrapping over n channels.
    function automatic int wrap_idx(input int base, input int k, input int n);
        return (base + 1 + k) % n;
    endfunction

endpackage

// File: rtl/jtkiwi_romarb_slot.sv
// One-entry read cache for a single ROM client channel.
module jtkiwi_romarb_slot #(
    parameter int AW   = 22,
    parameter int DW   = 16,
    parameter int KEEP = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_data,
    output logic          ok,
    output logic [DW-1:0] data
);

    logic          valid_reg;
    logic [AW-1:0] tag_reg;
    logic [DW-1:0] data_reg;

    // A fill takes precedence over the cs-low invalidation when KEEP is off.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
            data_reg  <= '0;
        end else if (fill) begin
            valid_reg <= 1'b1;
            tag_reg   <= fill_addr;
            data_reg  <= fill_data;
        end else if (KEEP == 0 && !cs) begin
            valid_reg <= 1'b0;
        end
    end

    assign ok   = cs & valid_reg & (tag_reg == addr);
    assign data = data_reg;

endmodule

// File: rtl/jtkiwi_romarb.sv
// Arbitrates CH cached ROM clients onto a single SDRAM read port, one request in flight.
module jtkiwi_romarb
    import jtkiwi_romarb_pkg::*;
#(
    parameter int CH   = 4,
    parameter int AW   = 22,
    parameter int DW   = 16,
    parameter int RR   = 1,
    parameter int KEEP = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [CH-1:0]    ch_cs,
    input  logic [CH*AW-1:0] ch_addr,
    output logic [CH-1:0]    ch_ok,
    output logic [CH*DW-1:0] ch_data,
    output logic             sd_req,
    output logic [AW-1:0]    sd_addr,
    input  logic             sd_ack,
    input  logic             sd_dst,
    input  logic [DW-1:0]    sd_din
);

    localparam int IW = (CH > 1) ? $clog2(CH) : 1;

    state_t        state_reg, state_next;
    logic [IW-1:0] gnt_reg, last_reg, pick;
    logic [AW-1:0] addr_reg;
    logic          found;
    logic          grant_take;
    logic          fill_en;
    logic [CH-1:0] pend;
    logic [AW-1:0] addr_arr [CH];

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_slot
            assign addr_arr[gi] = ch_addr[gi*AW +: AW];
            assign pend[gi]     = ch_cs[gi] & ~ch_ok[gi];

            jtkiwi_romarb_slot #(
                .AW   (AW),
                .DW   (DW),
                .KEEP (KEEP)
            ) u_slot (
                .clk       (clk),
                .rstn      (rstn),
                .cs        (ch_cs[gi]),
                .addr      (addr_arr[gi]),
                .fill      (fill_en && (gnt_reg == IW'(gi))),
                .fill_addr (addr_reg),
                .fill_data (sd_din),
                .ok        (ch_ok[gi]),
                .data      (ch_data[gi*DW +: DW])
            );
        end
    endgenerate

    // Scan candidates in priority order; the first pending one wins.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < CH_MAX; k++) begin
            idx = (RR != 0) ? wrap_idx(int'(last_reg), k, CH) : (k % CH);
            if (k < CH && !found && pend[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            gnt_reg   <= '0;
            last_reg  <= IW'(CH - 1);
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_take) begin
                gnt_reg  <= pick;
                last_reg <= pick;
                addr_reg <= addr_arr[pick];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_take = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (found) begin
                    grant_take = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (sd_ack) begin
                    state_next = sd_dst ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sd_dst) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Data arriving in IDLE (e.g. a reply to a request abandoned by reset) is dropped.
    always_comb begin
        sd_req  = (state_reg == ST_REQ);
        sd_addr = addr_reg;
        fill_en = sd_dst && ((state_reg == ST_WAIT) || (state_reg == ST_REQ && sd_ack));
    end

endmodule

// File: tb/tb_jtkiwi_romarb.sv
// Scoreboard bench: two arbiter configurations, expected SDRAM addresses queued per instance.
module tb_jtkiwi_romarb;

    localparam int CH = 4;
    localparam int AW = 22;
    localparam int DW = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [CH-1:0]    a_cs = '0, b_cs = '0;
    logic [CH*AW-1:0] a_addr_v = '0, b_addr_v = '0;
    logic [CH-1:0]    a_ok, b_ok;
    logic [CH*DW-1:0] a_data, b_data;
    logic             a_req, b_req;
    logic [AW-1:0]    a_sdaddr, b_sdaddr;
    logic             a_ack = 1'b0, a_dst = 1'b0, b_ack = 1'b0, b_dst = 1'b0;
    logic [DW-1:0]    a_din = '0, b_din = '0;

    jtkiwi_romarb #(.CH(CH), .AW(AW), .DW(DW), .RR(1), .KEEP(1)) dut_a (
        .clk(clk), .rstn(rstn), .ch_cs(a_cs), .ch_addr(a_addr_v), .ch_ok(a_ok),
        .ch_data(a_data), .sd_req(a_req), .sd_addr(a_sdaddr), .sd_ack(a_ack),
        .sd_dst(a_dst), .sd_din(a_din)
    );

    jtkiwi_romarb #(.CH(CH), .AW(AW), .DW(DW), .RR(0), .KEEP(0)) dut_b (
        .clk(clk), .rstn(rstn), .ch_cs(b_cs), .ch_addr(b_addr_v), .ch_ok(b_ok),
        .ch_data(b_data), .sd_req(b_req), .sd_addr(b_sdaddr), .sd_ack(b_ack),
        .sd_dst(b_dst), .sd_din(b_din)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [AW-1:0] exp_a [$];
    logic [AW-1:0] exp_b [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every accepted SDRAM request is matched against the next expected address.
    always @(negedge clk) begin
        if (rstn && a_req && a_ack) begin
            if (exp_a.size() == 0) chk("a_sb_underflow", 64'(exp_a.size()), 64'd1);
            else chk("a_sd_addr", 64'(a_sdaddr), 64'(exp_a.pop_front()));
            $display("A req addr %h", a_sdaddr);
        end
        if (rstn && b_req && b_ack) begin
            if (exp_b.size() == 0) chk("b_sb_underflow", 64'(exp_b.size()), 64'd1);
            else chk("b_sd_addr", 64'(b_sdaddr), 64'(exp_b.pop_front()));
            $display("B req addr %h", b_sdaddr);
        end
    end

    function automatic logic ok_of(input bit b, input int n);
        return b ? b_ok[n] : a_ok[n];
    endfunction

    function automatic logic [DW-1:0] dat_of(input bit b, input int n);
        return b ? b_data[n*DW +: DW] : a_data[n*DW +: DW];
    endfunction

    task automatic set_ch(input bit b, input int n, input bit cs, input logic [AW-1:0] ad);
        if (b) begin b_cs[n] = cs; b_addr_v[n*AW +: AW] = ad; end
        else   begin a_cs[n] = cs; a_addr_v[n*AW +: AW] = ad; end
    endtask

    task automatic drive(input bit b, input bit ack, input bit dst, input logic [DW-1:0] d);
        if (b) begin b_ack = ack; b_dst = dst; b_din = d; end
        else   begin a_ack = ack; a_dst = dst; a_din = d; end
    endtask

    task automatic wait_req(input bit b);
        int t = 0;
        while (!(b ? b_req : a_req) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) chk(b ? "b_req_timeout" : "a_req_timeout", 64'(t), 64'd0);
    endtask

    // dst_d == 0 returns data in the same cycle as the ack.
    task automatic respond(input bit b, input int ack_d, input int dst_d, input logic [DW-1:0] d);
        repeat (ack_d) begin @(posedge clk); #1; end
        drive(b, 1'b1, (dst_d == 0), d);
        @(posedge clk); #1;
        drive(b, 1'b0, 1'b0, d);
        if (dst_d > 0) begin
            repeat (dst_d - 1) begin @(posedge clk); #1; end
            drive(b, 1'b0, 1'b1, d);
            @(posedge clk); #1;
            drive(b, 1'b0, 1'b0, d);
        end
    endtask

    task automatic serve(input bit b, input int ack_d, input int dst_d, input logic [DW-1:0] d);
        wait_req(b);
        respond(b, ack_d, dst_d, d);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ok",   64'(a_ok), 64'd0);
        chk("rst_a_req",  64'(a_req), 64'd0);
        chk("rst_a_addr", 64'(a_sdaddr), 64'd0);
        chk("rst_a_data", 64'(a_data), 64'd0);
        chk("rst_b_req",  64'(b_req), 64'd0);
        @(posedge clk); #1 rstn = 1'b1;

        // Basic miss: latency of sd_req and ch_ok
        @(posedge clk); #1;
        set_ch(0, 0, 1, 22'h1234);
        exp_a.push_back(22'h1234);
        @(negedge clk); chk("a_req_before", 64'(a_req), 64'd0);
        @(negedge clk); chk("a_req_after1", 64'(a_req), 64'd1);
        chk("a_ok0_miss", 64'(a_ok[0]), 64'd0);
        serve(0, 2, 3, 16'hBEEF);
        chk("a_ok0_fill", 64'(ok_of(0, 0)), 64'd1);
        chk("a_data0", 64'(dat_of(0, 0)), 64'hBEEF);
        $display("T1 miss fill done");

        // KEEP=1: re-hit after cs low
        set_ch(0, 0, 0, 22'h1234);
        repeat (5) begin @(posedge clk); #1; end
        set_ch(0, 0, 1, 22'h1234);
        #1 chk("a_keep_hit", 64'(a_ok[0]), 64'd1);
        repeat (4) begin @(negedge clk); chk("a_keep_noreq", 64'(a_req), 64'd0); end
        @(posedge clk); #1 set_ch(0, 0, 0, 22'h1234);
        $display("T2 keep hit done");

        // Round robin from reset
        rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        for (int n = 0; n < CH; n++) begin
            set_ch(0, n, 1, 22'(22'h100 + n));
            exp_a.push_back(22'(22'h100 + n));
        end
        for (int n = 0; n < CH; n++) begin
            serve(0, 1, 1, 16'(16'h1000 + n));
            chk("a_rr_ok", 64'(ok_of(0, n)), 64'd1);
            chk("a_rr_data", 64'(dat_of(0, n)), 64'(16'h1000 + n));
            $display("T3 rr grant %0d filled", n);
        end
        chk("a_rr_all_ok", 64'(a_ok), 64'hF);
        a_cs = '0;

        // Address change while waiting: latched tag kept, miss re-arbitrates
        @(posedge clk); #1;
        set_ch(0, 2, 1, 22'h10);
        exp_a.push_back(22'h10);
        exp_a.push_back(22'h20);
        wait_req(0);
        drive(0, 1'b1, 1'b0, '0);
        @(posedge clk); #1 drive(0, 1'b0, 1'b0, '0);
        set_ch(0, 2, 1, 22'h20);
        @(posedge clk); #1 drive(0, 1'b0, 1'b1, 16'h5A5A);
        @(posedge clk); #1 drive(0, 1'b0, 1'b0, '0);
        chk("a_chg_ok2", 64'(a_ok[2]), 64'd0);
        chk("a_chg_data2", 64'(dat_of(0, 2)), 64'h5A5A);
        serve(0, 1, 2, 16'h6B6B);
        chk("a_chg_ok2_refill", 64'(a_ok[2]), 64'd1);
        chk("a_chg_data2_refill", 64'(dat_of(0, 2)), 64'h6B6B);
        $display("T4 addr change done");
        a_cs = '0;

        // Same-cycle ack and data, next pending channel requests after one idle cycle
        @(posedge clk); #1;
        set_ch(0, 0, 1, 22'h300);
        set_ch(0, 1, 1, 22'h301);
        exp_a.push_back(22'h300);
        exp_a.push_back(22'h301);
        wait_req(0);
        respond(0, 0, 0, 16'hC0C0);
        chk("a_same_ok0", 64'(a_ok[0]), 64'd1);
        chk("a_same_data0", 64'(dat_of(0, 0)), 64'hC0C0);
        chk("a_same_idle", 64'(a_req), 64'd0);
        @(posedge clk); #1 chk("a_same_next_req", 64'(a_req), 64'd1);
        serve(0, 0, 1, 16'hC1C1);
        chk("a_same_ok1", 64'(a_ok[1]), 64'd1);
        chk("a_same_data1", 64'(dat_of(0, 1)), 64'hC1C1);
        $display("T5 same-cycle ack/dst done");
        a_cs = '0;

        // KEEP=0: cs low invalidates
        @(posedge clk); #1;
        set_ch(1, 0, 1, 22'h1234);
        exp_b.push_back(22'h1234);
        serve(1, 0, 1, 16'h1111);
        chk("b_ok0", 64'(b_ok[0]), 64'd1);
        set_ch(1, 0, 0, 22'h1234);
        repeat (5) begin @(posedge clk); #1; end
        set_ch(1, 0, 1, 22'h1234);
        #1 chk("b_nokeep_miss", 64'(b_ok[0]), 64'd0);
        exp_b.push_back(22'h1234);
        serve(1, 0, 1, 16'h2222);
        chk("b_nokeep_refill", 64'(dat_of(1, 0)), 64'h2222);
        $display("T6 keep=0 done");

        // Fixed priority: channel 0 keeps missing and keeps winning
        set_ch(1, 1, 1, 22'h50);
        set_ch(1, 0, 1, 22'h60);
        for (int r = 0; r < 3; r++) begin
            exp_b.push_back(22'(22'h60 + r));
            serve(1, 0, 1, 16'(16'h7000 + r));
            chk("b_fp_ok0", 64'(b_ok[0]), 64'd1);
            chk("b_fp_data0", 64'(dat_of(1, 0)), 64'(16'h7000 + r));
            if (r < 2) set_ch(1, 0, 1, 22'(22'h61 + r));
            else       set_ch(1, 0, 0, 22'h62);
            $display("T7 fixed priority round %0d", r);
        end
        exp_b.push_back(22'h50);
        serve(1, 0, 1, 16'h5050);
        chk("b_fp_ok1", 64'(b_ok[1]), 64'd1);
        b_cs = '0;

        // Reset during WAIT abandons the request
        @(posedge clk); #1;
        set_ch(0, 3, 1, 22'h400);
        exp_a.push_back(22'h400);
        wait_req(0);
        drive(0, 1'b1, 1'b0, '0);
        @(posedge clk); #1 drive(0, 1'b0, 1'b0, '0);
        rstn = 1'b0;
        a_cs = '0;
        @(negedge clk);
        chk("a_rst_req", 64'(a_req), 64'd0);
        @(posedge clk); #1 rstn = 1'b1;
        drive(0, 1'b0, 1'b1, 16'hDEAD);
        @(posedge clk); #1 drive(0, 1'b0, 1'b0, '0);
        chk("a_rst_ok", 64'(a_ok), 64'd0);
        chk("a_rst_req2", 64'(a_req), 64'd0);
        chk("a_rst_data", 64'(a_data), 64'd0);
        set_ch(0, 3, 1, 22'h400);
        #1 chk("a_rst_ok3", 64'(a_ok[3]), 64'd0);
        exp_a.push_back(22'h400);
        serve(0, 0, 1, 16'h4444);
        chk("a_rst_refill", 64'(dat_of(0, 3)), 64'h4444);
        $display("T8 reset mid-request done");
        a_cs = '0;

        repeat (3) @(posedge clk);
        chk("a_sb_left", 64'(exp_a.size()), 64'd0);
        chk("b_sb_left", 64'(exp_b.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/jtkiwi_romarb.md
JTKIWI_ROMARB -- requirements
Module: jtkiwi_romarb

Interface
REQ-001 The module SHALL have parameter CH, default 4, number of ROM client channels (2..8).
REQ-002 The module SHALL have parameter AW, default 22, client and SDRAM word address width.
REQ-003 The module SHALL have parameter DW, default 16, data width.
REQ-004 The module SHALL have parameter RR, default 1; 1 selects round-robin arbitration, 0 selects fixed priority (lowest index wins).
REQ-005 The module SHALL have parameter KEEP, default 1; 1 retains cached data while cs is low, 0 invalidates a channel's cache when its cs is low.
REQ-006 The module SHALL have port clk, input, 1, sole clock; one clock; reset is asynchronous and active-low.
REQ-007 The module SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-008 The module SHALL have port ch_cs, input, CH, per-channel read request.
REQ-009 The module SHALL have port ch_addr, input, CH*AW, per-channel address, channel n at bits n*AW+:AW.
REQ-010 The module SHALL have port ch_ok, output, CH, per-channel data valid.
REQ-011 The module SHALL have port ch_data, output, CH*DW, per-channel data, packed like ch_addr.
REQ-012 The module SHALL have port sd_req, output, 1, SDRAM read request.
REQ-013 The module SHALL have port sd_addr, output, AW, SDRAM read address.
REQ-014 The module SHALL have port sd_ack, input, 1, SDRAM accepted the request.
REQ-015 The module SHALL have port sd_dst, input, 1, SDRAM read data valid this cycle.
REQ-016 The module SHALL have port sd_din, input, DW, SDRAM read data.

Function
REQ-017 Each channel SHALL hold a one-entry cache: valid bit, AW-bit tag, DW-bit data.
REQ-018 ch_ok[n] SHALL be combinational: ch_cs[n] AND valid[n] AND tag[n]==ch_addr[n]; ch_data[n] SHALL always drive data[n].
REQ-019 A channel SHALL be pending when ch_cs[n] is high and ch_ok[n] is low.
REQ-020 The FSM SHALL have states IDLE, REQ and WAIT.
REQ-021 In IDLE with any channel pending, the FSM SHALL latch the grant index and its ch_addr into sd_addr, assert sd_req, and enter REQ on the next edge.
REQ-022 The grant in RR=1 SHALL go to the first pending index after the last granted index, wrapping modulo CH; the grant in RR=0 SHALL go to the lowest pending index.
REQ-023 In REQ, sd_req and sd_addr SHALL hold stable until sd_ack; on sd_ack, sd_req SHALL drop on the next edge and the FSM SHALL enter WAIT.
REQ-024 In WAIT (or REQ with sd_ack and sd_dst in the same cycle), sd_dst SHALL write sd_din and the latched address into the granted channel's cache, set valid, and return to IDLE.
REQ-025 Minimum miss-to-ok latency SHALL be: sd_req high 1 cycle after cs; ch_ok high 1 cycle after sd_dst.
REQ-026 An address change or cs drop during an outstanding request SHALL NOT abort it; the fill SHALL complete with the latched tag, and a changed address SHALL remain a miss that re-arbitrates.
REQ-027 A fill SHALL affect only the granted channel; other channels' caches SHALL be untouched.
REQ-028 With KEEP=0, valid[n] SHALL clear on any cycle ch_cs[n] is low, except on the cycle a fill writes channel n.
REQ-029 Only one SDRAM request SHALL be outstanding at any time.

Reset
REQ-030 While rstn is low: all valid=0, tags=0, data=0, ch_ok=0, sd_req=0, sd_addr=0, FSM=IDLE, last-grant pointer=CH-1 so channel 0 wins first.
REQ-031 Reset mid-request SHALL abandon it; sd_dst arriving after release SHALL be ignored in IDLE.

Structure
REQ-032 A package jtkiwi_romarb_pkg SHALL hold the FSM state enum and the CH range limits.
REQ-033 The per-channel cache SHALL be a sub-module jtkiwi_romarb_slot, instantiated CH times.

Verification
REQ-034 Channel 0 cs=1, addr=0x1234, sd_ack 2 cycles later, sd_dst with 0xBEEF 3 cycles after that -> sd_addr=0x1234, ch_ok[0]=1 with ch_data=0xBEEF one cycle after sd_dst.
REQ-035 Repeat addr 0x1234 after cs low 5 cycles, KEEP=1 -> ch_ok[0]=1 combinationally, no sd_req; KEEP=0 -> new SDRAM request.
REQ-036 RR=1, channels 0..3 all pending from reset -> grant order 0,1,2,3; RR=0 with channel 0 re-missing each time -> channel 0 granted every time.
REQ-037 Channel 2 changes addr 0x10->0x20 while in WAIT -> fill stores tag 0x10, ch_ok[2] stays 0, next sd_addr=0x20.
REQ-038 sd_ack and sd_dst in the same cycle -> fill happens, FSM returns to IDLE, next pending channel's sd_req is asserted 1 cycle later.
REQ-039 rstn pulsed low in WAIT, then sd_dst -> no cache written, all ch_ok=0, sd_req=0.
